// File: rtl/gpio_pwm_ctrl.sv
// gpio_pwm_ctrl: Wishbone-slave GPIO bank with PWM channels and edge interrupts.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   cyc_i, stb_i, we_i  Wishbone cycle / strobe / write enable
//   addr_i, data_i      byte address (only [7:0] decoded) and write data
//   data_o, ack_o       registered read data and single-cycle acknowledge
//   gpio_i              raw asynchronous pad inputs
//   gpio_o, gpio_oe     pad output values and output enables (1 = drive)
//   irq_o               level interrupt, OR of enabled pending edge flags
//
// Register map (addr_i[7:0]):
//   0x00 DIR, 0x04 OUT, 0x08 IN (ro), 0x0C PWM_EN, 0x10 IRQ_EN,
//   0x14 IRQ_POL (1 rising, 0 falling), 0x18 IRQ_STAT (write 1 to clear),
//   0x20+8k PWM_PERIOD[k], 0x24+8k PWM_DUTY[k] (reads return pending value)
module gpio_pwm_ctrl #(
    parameter int WIDTH       = 20,
    parameter int PWM_CH      = 4,
    parameter int PWM_BITS    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cyc_i,
    input  logic             stb_i,
    input  logic             we_i,
    input  logic [31:0]      addr_i,
    input  logic [31:0]      data_i,
    output logic [31:0]      data_o,
    output logic             ack_o,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq_o
);

    logic                ack_q;
    logic [31:0]         data_q;
    logic [WIDTH-1:0]    dir_q, out_q, irqEn_q, irqPol_q, irqStat_q, irqStat_d;
    logic [PWM_CH-1:0]   pwmEn_q, pwm_q;
    logic [PWM_BITS-1:0] perPend_q  [PWM_CH];
    logic [PWM_BITS-1:0] dutyPend_q [PWM_CH];
    logic [PWM_BITS-1:0] perAct_q   [PWM_CH];
    logic [PWM_BITS-1:0] dutyAct_q  [PWM_CH];
    logic [PWM_BITS-1:0] cnt_q      [PWM_CH];
    logic [WIDTH-1:0]    sync_q     [SYNC_STAGES];
    logic [WIDTH-1:0]    prev_q;
    logic                irq_q;

    logic                req, wrEn;
    logic [7:0]          addr8;
    logic [31:0]         rdata_d;
    logic [WIDTH-1:0]    syncNow, rise, fall, edgeSet, w1c;
    logic                unused_ok;

    // A request is only accepted while no ack is outstanding, so each bus
    // cycle produces exactly one ack.
    assign req   = cyc_i & stb_i & ~ack_q;
    assign wrEn  = req & we_i;
    assign addr8 = addr_i[7:0];

    assign unused_ok = ^{addr_i[31:8], data_i};

    function automatic logic [7:0] perAddr(input int k);
        return 8'(32 + 8 * k);
    endfunction

    always_comb begin
        rdata_d = '0;
        case (addr8)
            8'h00:   rdata_d = 32'(dir_q);
            8'h04:   rdata_d = 32'(out_q);
            8'h08:   rdata_d = 32'(syncNow);
            8'h0C:   rdata_d = 32'(pwmEn_q);
            8'h10:   rdata_d = 32'(irqEn_q);
            8'h14:   rdata_d = 32'(irqPol_q);
            8'h18:   rdata_d = 32'(irqStat_q);
            default: rdata_d = '0;
        endcase
        for (int k = 0; k < PWM_CH; k++) begin
            if (addr8 == perAddr(k))         rdata_d = 32'(perPend_q[k]);
            if (addr8 == perAddr(k) + 8'd4)  rdata_d = 32'(dutyPend_q[k]);
        end
    end

    // Edge detection compares the last synchroniser stage against one more
    // delayed copy; a new edge outranks a simultaneous write-1-to-clear.
    assign syncNow   = sync_q[SYNC_STAGES-1];
    assign rise      = syncNow & ~prev_q;
    assign fall      = ~syncNow & prev_q;
    assign edgeSet   = irqEn_q & ((irqPol_q & rise) | (~irqPol_q & fall));
    assign w1c       = (wrEn && addr8 == 8'h18) ? data_i[WIDTH-1:0] : '0;
    assign irqStat_d = (irqStat_q & ~w1c) | edgeSet;

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q     <= 1'b0;
            data_q    <= '0;
            dir_q     <= '0;
            out_q     <= '0;
            pwmEn_q   <= '0;
            irqEn_q   <= '0;
            irqPol_q  <= '0;
            irqStat_q <= '0;
            for (int k = 0; k < PWM_CH; k++) begin
                perPend_q[k]  <= '0;
                dutyPend_q[k] <= '0;
            end
        end else begin
            ack_q     <= req;
            data_q    <= (req && !we_i) ? rdata_d : '0;
            irqStat_q <= irqStat_d;
            if (wrEn) begin
                case (addr8)
                    8'h00:   dir_q    <= data_i[WIDTH-1:0];
                    8'h04:   out_q    <= data_i[WIDTH-1:0];
                    8'h0C:   pwmEn_q  <= data_i[PWM_CH-1:0];
                    8'h10:   irqEn_q  <= data_i[WIDTH-1:0];
                    8'h14:   irqPol_q <= data_i[WIDTH-1:0];
                    default: ;
                endcase
                for (int k = 0; k < PWM_CH; k++) begin
                    if (addr8 == perAddr(k))        perPend_q[k]  <= data_i[PWM_BITS-1:0];
                    if (addr8 == perAddr(k) + 8'd4) dutyPend_q[k] <= data_i[PWM_BITS-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            prev_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            sync_q[0] <= gpio_i;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            prev_q <= syncNow;
            irq_q  <= |(irqStat_q & irqEn_q);
        end
    end

    // The active period/duty only reload from the pending copy at the wrap
    // point (or while disabled), so a running period is never cut short.
    always_ff @(posedge clk) begin
        for (int k = 0; k < PWM_CH; k++) begin
            if (rst) begin
                cnt_q[k]     <= '0;
                pwm_q[k]     <= 1'b0;
                perAct_q[k]  <= '0;
                dutyAct_q[k] <= '0;
            end else if (!pwmEn_q[k]) begin
                cnt_q[k]     <= '0;
                pwm_q[k]     <= 1'b0;
                perAct_q[k]  <= perPend_q[k];
                dutyAct_q[k] <= dutyPend_q[k];
            end else begin
                pwm_q[k] <= (cnt_q[k] < dutyAct_q[k]);
                if (cnt_q[k] >= perAct_q[k]) begin
                    cnt_q[k]     <= '0;
                    perAct_q[k]  <= perPend_q[k];
                    dutyAct_q[k] <= dutyPend_q[k];
                end else begin
                    cnt_q[k] <= cnt_q[k] + PWM_BITS'(1);
                end
            end
        end
    end

    always_comb begin
        gpio_o  = out_q;
        gpio_oe = dir_q;
        for (int k = 0; k < PWM_CH; k++) begin
            if (pwmEn_q[k]) begin
                gpio_o[k]  = pwm_q[k];
                gpio_oe[k] = 1'b1;
            end
        end
    end

    assign ack_o  = ack_q;
    assign data_o = data_q;
    assign irq_o  = irq_q;

endmodule
